axis_byte_packer: RTL and testbench

- Downstream neighbour of the process stage. Consumes its 8-bit AXI-Stream output, which has no tready, and packs the bytes into 64-bit words for the DMA S2MM channel.
- Absorbs DMA backpressure in an internal FIFO. If the FIFO overflows, the word is dropped and a sticky error flag is raised.
- Sits between process and the m00_axis ports of top.

---
 rtl/horner_pkg.sv | 26 ++
 rtl/axis_byte_packer_if.sv | 30 +++
 rtl/horner_sync_fifo.sv | 56 +++++
 rtl/axis_byte_packer.sv | 107 ++++++++++
 tb/tb_axis_byte_packer.sv | 355 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/horner_pkg.sv
// Shared definitions for the byte packer and its word FIFO.
// Default lane/word/depth sizes, and helpers that give the FIFO entry width
// and the bit offsets of the {last, keep, data} fields inside an entry.
package horner_pkg;

  localparam int IN_W_DEF       = 8;
  localparam int OUT_W_DEF      = 64;
  localparam int FIFO_DEPTH_DEF = 16;

  localparam int BYTES_PER_WORD = OUT_W_DEF / IN_W_DEF;
  localparam int KEEP_W         = BYTES_PER_WORD;

  // Entry layout, MSB to LSB: {last, keep[out_w/in_w-1:0], data[out_w-1:0]}
  function automatic int entry_width(input int out_w, input int in_w);
    return out_w + (out_w / in_w) + 1;
  endfunction

  function automatic int keep_lsb(input int out_w);
    return out_w;
  endfunction

  function automatic int last_bit(input int out_w, input int in_w);
    return out_w + (out_w / in_w);
  endfunction

endpackage

// File: rtl/axis_byte_packer_if.sv
// Stream bundle around the byte packer.
// s_tdata/s_tvalid/s_tlast : byte stream in (no tready, every beat is taken)
// m_tdata/m_tkeep/m_tlast/m_tvalid/m_tready : packed word stream out
// Modport slave is the packer's view; modport master is the view of the
// surroundings (byte source plus word sink).
interface axis_byte_packer_if #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 64
);
  localparam int KEEP_W = OUT_W / IN_W;

  logic [IN_W-1:0]   s_tdata;
  logic              s_tvalid;
  logic              s_tlast;
  logic [OUT_W-1:0]  m_tdata;
  logic [KEEP_W-1:0] m_tkeep;
  logic              m_tlast;
  logic              m_tvalid;
  logic              m_tready;

  modport slave (
    input  s_tdata, s_tvalid, s_tlast, m_tready,
    output m_tdata, m_tkeep, m_tlast, m_tvalid
  );

  modport master (
    output s_tdata, s_tvalid, s_tlast, m_tready,
    input  m_tdata, m_tkeep, m_tlast, m_tvalid
  );
endinterface

// File: rtl/horner_sync_fifo.sv
// First-word-fall-through synchronous FIFO.
// clk, rst_n (sync, active-low), push/din, pop/dout, full, empty, level.
// dout shows the head entry and reads 0 while empty. A push while full is
// taken only when a pop happens in the same cycle.
module horner_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [AW:0] FULL_LEVEL = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (level == '0);
  assign full    = (level == FULL_LEVEL);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  // Storage carries no reset; empty gating keeps stale entries invisible.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end
endmodule

// File: rtl/axis_byte_packer.sv
// Packs an 8-bit tready-less byte stream into 64-bit words for a DMA.
// aclk, aresetn (sync, active-low); bus.slave carries s_* in and m_* out;
// overflow is a sticky flag for a completed word dropped on a full FIFO;
// fifo_level is the current word FIFO occupancy.
// Bytes fill lanes little-endian; a word completes on the last lane or on
// s_tlast and is pushed into the FIFO at that same clock edge.
module axis_byte_packer
  import horner_pkg::*;
#(
  parameter int IN_W       = IN_W_DEF,
  parameter int OUT_W      = OUT_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  axis_byte_packer_if.slave           bus,
  output logic                        overflow,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
  localparam int N        = OUT_W / IN_W;
  localparam int IDX_W    = (N > 1) ? $clog2(N) : 1;
  localparam int EW       = entry_width(OUT_W, IN_W);
  localparam int KEEP_LSB = keep_lsb(OUT_W);
  localparam int LAST_BIT = last_bit(OUT_W, IN_W);
  localparam logic [IDX_W-1:0] LAST_LANE = IDX_W'(N - 1);

  logic [IDX_W-1:0] idx_p0;
  logic [OUT_W-1:0] asm_data_p0;
  logic [N-1:0]     asm_keep_p0;

  logic [OUT_W-1:0] word_data;
  logic [N-1:0]     word_keep;
  logic             word_done;
  logic [EW-1:0]    push_entry;
  logic [EW-1:0]    head_entry;
  logic             fifo_full;
  logic             fifo_empty;
  logic             pop;
  logic             push;
  logic             drop;

  // Word as it would look with the current byte merged into its lane.
  always_comb begin
    word_data = asm_data_p0;
    word_keep = asm_keep_p0;
    word_data[idx_p0*IN_W +: IN_W] = bus.s_tdata;
    word_keep[idx_p0] = 1'b1;
  end

  assign word_done = bus.s_tvalid && ((idx_p0 == LAST_LANE) || bus.s_tlast);

  always_comb begin
    push_entry = '0;
    push_entry[OUT_W-1:0]       = word_data;
    push_entry[KEEP_LSB +: N]   = word_keep;
    push_entry[LAST_BIT]        = bus.s_tlast;
  end

  // A full FIFO still accepts a word when the head leaves in the same cycle.
  assign pop  = bus.m_tvalid && bus.m_tready;
  assign push = word_done && (!fifo_full || pop);
  assign drop = word_done && fifo_full && !pop;

  // ---- stage p0: lane counter and assembly register ----
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      idx_p0      <= '0;
      asm_data_p0 <= '0;
      asm_keep_p0 <= '0;
      overflow    <= 1'b0;
    end else begin
      if (bus.s_tvalid) begin
        if (word_done) begin
          idx_p0      <= '0;
          asm_data_p0 <= '0;
          asm_keep_p0 <= '0;
        end else begin
          idx_p0      <= idx_p0 + IDX_W'(1);
          asm_data_p0 <= word_data;
          asm_keep_p0 <= word_keep;
        end
      end
      if (drop) overflow <= 1'b1;
    end
  end

  // ---- stage p1: word FIFO toward the DMA ----
  horner_sync_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (aclk),
    .rst_n (aresetn),
    .push  (push),
    .din   (push_entry),
    .pop   (pop),
    .dout  (head_entry),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign bus.m_tvalid = !fifo_empty;
  assign bus.m_tdata  = head_entry[OUT_W-1:0];
  assign bus.m_tkeep  = head_entry[KEEP_LSB +: N];
  assign bus.m_tlast  = head_entry[LAST_BIT];
endmodule

// File: tb/tb_axis_byte_packer.sv
`timescale 1ns/1ps
module tb_axis_byte_packer;
  import horner_pkg::*;

  localparam int N     = BYTES_PER_WORD;
  localparam int DEPTH = FIFO_DEPTH_DEF;

  typedef struct {
    logic [OUT_W_DEF-1:0] data;
    logic [KEEP_W-1:0]    keep;
    logic                 last;
  } exp_t;

  logic                    aclk = 1'b0;
  logic                    aresetn = 1'b0;
  logic                    overflow;
  logic [$clog2(DEPTH):0]  fifo_level;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  exp_t                 sb[$];
  logic [OUT_W_DEF-1:0] m_data = '0;
  logic [KEEP_W-1:0]    m_keep = '0;
  int                   m_idx  = 0;
  logic                 m_ovf  = 1'b0;

  axis_byte_packer_if #(.IN_W(IN_W_DEF), .OUT_W(OUT_W_DEF)) bus();

  axis_byte_packer #(
    .IN_W       (IN_W_DEF),
    .OUT_W      (OUT_W_DEF),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .bus        (bus),
    .overflow   (overflow),
    .fifo_level (fifo_level)
  );

  always #5 aclk = ~aclk;

  // Byte-level reference: checks the outputs left by the previous edge, then
  // folds in the inputs that the next rising edge will sample.
  always @(negedge aclk) begin
    exp_t e;
    int   n_before;
    bit   pop;
    bit   done;
    if (mon_en) begin
      checks++;
      if (bus.m_tvalid !== (sb.size() != 0)) begin
        errors++;
        $display("FAIL mon_tvalid: got %b want %b", bus.m_tvalid, (sb.size() != 0));
      end
      checks++;
      if ($isunknown(fifo_level) || int'(fifo_level) != sb.size()) begin
        errors++;
        $display("FAIL mon_level: got %0d want %0d", fifo_level, sb.size());
      end
      checks++;
      if (overflow !== m_ovf) begin
        errors++;
        $display("FAIL mon_overflow: got %b want %b", overflow, m_ovf);
      end
      if (sb.size() != 0 && bus.m_tvalid === 1'b1) begin
        checks++;
        if (bus.m_tdata !== sb[0].data || bus.m_tkeep !== sb[0].keep ||
            bus.m_tlast !== sb[0].last) begin
          errors++;
          $display("FAIL mon_head: got %h/%h/%b want %h/%h/%b", bus.m_tdata, bus.m_tkeep,
                   bus.m_tlast, sb[0].data, sb[0].keep, sb[0].last);
        end
      end
    end
    if (aresetn !== 1'b1) begin
      sb.delete();
      m_data = '0;
      m_keep = '0;
      m_idx  = 0;
      m_ovf  = 1'b0;
    end else begin
      n_before = sb.size();
      pop  = (n_before != 0) && (bus.m_tready === 1'b1);
      done = 1'b0;
      if (bus.s_tvalid === 1'b1) begin
        m_data[m_idx*IN_W_DEF +: IN_W_DEF] = bus.s_tdata;
        m_keep[m_idx] = 1'b1;
        if (m_idx == N - 1 || bus.s_tlast === 1'b1) begin
          e.data = m_data;
          e.keep = m_keep;
          e.last = bus.s_tlast;
          done   = 1'b1;
          m_data = '0;
          m_keep = '0;
          m_idx  = 0;
        end else begin
          m_idx++;
        end
      end
      if (pop) void'(sb.pop_front());
      if (done) begin
        if (n_before < DEPTH || pop) sb.push_back(e);
        else m_ovf = 1'b1;
      end
    end
  end

  task automatic drive_byte(input logic [7:0] b, input logic last);
    @(posedge aclk); #1;
    bus.s_tvalid = 1'b1;
    bus.s_tdata  = b;
    bus.s_tlast  = last;
  endtask

  task automatic drive_idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge aclk); #1;
      bus.s_tvalid = 1'b0;
      bus.s_tlast  = 1'b0;
      bus.s_tdata  = '0;
    end
  endtask

  task automatic pulse_reset();
    @(posedge aclk); #1;
    aresetn = 1'b0;
    @(posedge aclk); #1;
    aresetn = 1'b1;
  endtask

  task automatic drain(input int budget);
    int c = 0;
    @(posedge aclk); #1;
    bus.s_tvalid = 1'b0;
    bus.m_tready = 1'b1;
    while (sb.size() != 0 && c < budget) begin
      @(posedge aclk); #1;
      c++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d words left want 0", sb.size());
    end
  endtask

  task automatic test_reset();
    bus.s_tvalid = 1'b0;
    bus.s_tdata  = '0;
    bus.s_tlast  = 1'b0;
    bus.m_tready = 1'b0;
    aresetn      = 1'b0;
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    checks++;
    if (bus.m_tvalid !== 1'b0 || bus.m_tdata !== '0 || bus.m_tkeep !== '0 ||
        bus.m_tlast !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b/%h/%h/%b want 0/0/0/0", bus.m_tvalid,
               bus.m_tdata, bus.m_tkeep, bus.m_tlast);
    end
    checks++;
    if (overflow !== 1'b0 || fifo_level !== '0) begin
      errors++;
      $display("FAIL reset_status: got ovf=%b lvl=%0d want 0/0", overflow, fifo_level);
    end
    @(posedge aclk); #1;
    aresetn = 1'b1;
    mon_en  = 1'b1;
  endtask

  task automatic test_full_word();
    bus.m_tready = 1'b1;
    for (int b = 1; b <= 8; b++) drive_byte(8'(b), (b == 8));
    drive_idle(1);
    @(negedge aclk);
    checks++;
    if (bus.m_tvalid !== 1'b1 || bus.m_tdata !== 64'h0807060504030201 ||
        bus.m_tkeep !== 8'hFF || bus.m_tlast !== 1'b1) begin
      errors++;
      $display("FAIL full_word: got %b/%h/%h/%b want 1/0807060504030201/ff/1", bus.m_tvalid,
               bus.m_tdata, bus.m_tkeep, bus.m_tlast);
    end
    drive_idle(1);
    @(negedge aclk);
    checks++;
    if (bus.m_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL full_word_single_beat: got tvalid=%b want 0", bus.m_tvalid);
    end
  endtask

  task automatic test_partial();
    bus.m_tready = 1'b1;
    drive_byte(8'hAA, 1'b0);
    drive_byte(8'hBB, 1'b0);
    drive_byte(8'hCC, 1'b1);
    drive_idle(1);
    @(negedge aclk);
    checks++;
    if (bus.m_tvalid !== 1'b1 || bus.m_tdata !== 64'h0000000000CCBBAA ||
        bus.m_tkeep !== 8'h07 || bus.m_tlast !== 1'b1) begin
      errors++;
      $display("FAIL partial_word: got %b/%h/%h/%b want 1/0000000000ccbbaa/07/1", bus.m_tvalid,
               bus.m_tdata, bus.m_tkeep, bus.m_tlast);
    end
    for (int b = 0; b < 8; b++) drive_byte(8'(8'h21 + b), (b == 7));
    drive_idle(1);
    @(negedge aclk);
    checks++;
    if (bus.m_tdata !== 64'h2827262524232221 || bus.m_tkeep !== 8'hFF || bus.m_tlast !== 1'b1) begin
      errors++;
      $display("FAIL partial_next_lane0: got %h/%h/%b want 2827262524232221/ff/1",
               bus.m_tdata, bus.m_tkeep, bus.m_tlast);
    end
    drive_idle(2);
  endtask

  task automatic test_overflow();
    @(posedge aclk); #1;
    bus.m_tready = 1'b0;
    for (int k = 0; k < 136; k++) drive_byte(8'(k), 1'b0);
    drive_idle(1);
    @(negedge aclk);
    checks++;
    if (fifo_level !== 5'd16 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow_full: got lvl=%0d ovf=%b want 16/1", fifo_level, overflow);
    end
    checks++;
    if (bus.m_tdata !== 64'h0706050403020100) begin
      errors++;
      $display("FAIL overflow_head: got %h want 0706050403020100", bus.m_tdata);
    end
    drive_idle(3);
    @(negedge aclk);
    checks++;
    if (bus.m_tvalid !== 1'b1 || bus.m_tdata !== 64'h0706050403020100 || bus.m_tlast !== 1'b0) begin
      errors++;
      $display("FAIL overflow_stall_stable: got %b/%h/%b want 1/0706050403020100/0",
               bus.m_tvalid, bus.m_tdata, bus.m_tlast);
    end
    drain(40);
    @(negedge aclk);
    checks++;
    if (fifo_level !== '0 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow_after_drain: got lvl=%0d ovf=%b want 0/1", fifo_level, overflow);
    end
  endtask

  task automatic test_full_pop();
    pulse_reset();
    bus.m_tready = 1'b0;
    for (int k = 0; k < 135; k++) drive_byte(8'(8'h40 + k), 1'b0);
    @(posedge aclk); #1;
    bus.s_tvalid = 1'b1;
    bus.s_tdata  = 8'h40 + 8'd135;
    bus.s_tlast  = 1'b0;
    bus.m_tready = 1'b1;
    @(posedge aclk); #1;
    bus.s_tvalid = 1'b0;
    bus.m_tready = 1'b0;
    @(negedge aclk);
    checks++;
    if (fifo_level !== 5'd16 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL full_pop_level: got lvl=%0d ovf=%b want 16/0", fifo_level, overflow);
    end
    checks++;
    if (bus.m_tdata !== 64'h4F4E4D4C4B4A4948) begin
      errors++;
      $display("FAIL full_pop_head: got %h want 4f4e4d4c4b4a4948", bus.m_tdata);
    end
    drain(40);
  endtask

  task automatic test_reset_mid();
    bus.m_tready = 1'b1;
    for (int b = 0; b < 5; b++) drive_byte(8'(8'h51 + b), 1'b0);
    @(posedge aclk); #1;
    aresetn      = 1'b0;
    bus.s_tvalid = 1'b1;
    bus.s_tdata  = 8'h99;
    bus.s_tlast  = 1'b1;
    @(negedge aclk);
    @(posedge aclk); #1;
    checks++;
    if (bus.m_tvalid !== 1'b0 || bus.m_tdata !== '0 || bus.m_tkeep !== '0 ||
        bus.m_tlast !== 1'b0 || overflow !== 1'b0 || fifo_level !== '0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got %b/%h/%h/%b/%b/%0d want all 0", bus.m_tvalid,
               bus.m_tdata, bus.m_tkeep, bus.m_tlast, overflow, fifo_level);
    end
    aresetn      = 1'b1;
    bus.s_tvalid = 1'b0;
    bus.s_tlast  = 1'b0;
    for (int b = 0; b < 8; b++) drive_byte(8'(8'h11 + b), (b == 7));
    drive_idle(1);
    @(negedge aclk);
    checks++;
    if (bus.m_tvalid !== 1'b1 || bus.m_tdata !== 64'h1817161514131211 ||
        bus.m_tkeep !== 8'hFF || bus.m_tlast !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_word: got %b/%h/%h/%b want 1/1817161514131211/ff/1",
               bus.m_tvalid, bus.m_tdata, bus.m_tkeep, bus.m_tlast);
    end
    drive_idle(1);
    @(negedge aclk);
    checks++;
    if (bus.m_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_only_one: got tvalid=%b want 0", bus.m_tvalid);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 2000; c++) begin
      @(posedge aclk); #1;
      bus.s_tvalid = ($urandom_range(0, 9) < 8);
      bus.s_tdata  = 8'($urandom);
      bus.s_tlast  = bus.s_tvalid && ($urandom_range(0, 7) == 0);
      bus.m_tready = ($urandom_range(0, 4) != 0);
    end
    drain(100);
    @(negedge aclk);
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL random_overflow: got %b want 0", overflow);
    end
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_partial();
    test_overflow();
    test_full_pop();
    test_reset_mid();
    test_random();
    drive_idle(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
